// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants, execution-unit indices and the broadcast packet type.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_N_SRC  = 4;
  localparam int unsigned CDB_TAG_W  = 4;
  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned CDB_SRC_W  = $clog2(CDB_N_SRC);

  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_MUL = 2'd1,
    EXU_LSU = 2'd2,
    EXU_BR  = 2'd3
  } exu_id_e;

  typedef struct packed {
    logic                  vld;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit result handshake plus the registered CDB broadcast.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC  = CDB_N_SRC,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
);
  logic                      flush;
  logic [N_SRC-1:0]          src_req;
  logic [N_SRC-1:0]          src_rdy;
  logic [N_SRC*TAG_W-1:0]    src_tag;
  logic [N_SRC*DATA_W-1:0]   src_wdata;
  logic                      cdb_vld;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [$clog2(N_SRC)-1:0]  cdb_src;

  modport slave (
    input  flush, src_req, src_tag, src_wdata,
    output src_rdy, cdb_vld, cdb_tag, cdb_data, cdb_src
  );

  modport master (
    output flush, src_req, src_tag, src_wdata,
    input  src_rdy, cdb_vld, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr.sv
// Round-robin arbiter: search starts at ptr and wraps; ptr moves past each winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      if (!found && en && req[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt[IDX_W'(cand)]    = 1'b1;
        gnt_idx              = IDX_W'(cand);
      end
    end
  end

  // Explicit compare keeps the wrap correct for non-power-of-2 N.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      if (gnt_idx == IDX_W'(N - 1)) ptr_d = '0;
      else                          ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant over execution-unit results, one registered broadcast per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC  = CDB_N_SRC,
  parameter int unsigned TAG_W  = CDB_TAG_W,
  parameter int unsigned DATA_W = CDB_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]  gnt;
  logic [SRC_W-1:0]  gnt_idx;
  logic              arb_en;

  logic              vld_q, vld_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;

  // Reset and flush both suppress the grant so no result is accepted and lost.
  assign arb_en = ~rst & ~bus.flush;

  rr_arbiter #(.N(N_SRC)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.src_req),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.src_rdy = gnt;

  always_comb begin
    vld_d  = |gnt;
    tag_d  = tag_q;
    data_d = data_q;
    src_d  = src_q;
    if (vld_d) begin
      tag_d  = bus.src_tag[gnt_idx*TAG_W +: TAG_W];
      data_d = bus.src_wdata[gnt_idx*DATA_W +: DATA_W];
      src_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign bus.cdb_vld  = vld_q;
  assign bus.cdb_tag  = tag_q;
  assign bus.cdb_data = data_q;
  assign bus.cdb_src  = src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table with a broadcast scoreboard, then a fairness sweep.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_SRC(4), .TAG_W(4), .DATA_W(32)) bus ();

  cdb_arbiter #(.N_SRC(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit           rst;
    bit           flush;
    logic [3:0]   req;
    logic [15:0]  tags;
    logic [127:0] datas;
    logic [3:0]   exp_rdy;
  } vec_t;

  vec_t     vt[$];
  cdb_pkt_t sb[$];
  cdb_pkt_t held;
  int       n_chk  = 0;
  int       n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(bit r, bit f, logic [3:0] rq, logic [15:0] tg,
                              logic [127:0] dt, logic [3:0] er);
    vec_t v;
    v.rst = r; v.flush = f; v.req = rq; v.tags = tg; v.datas = dt; v.exp_rdy = er;
    vt.push_back(v);
  endfunction

  function automatic logic [1:0] oh2idx(logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  initial begin
    logic [127:0] da, db, dl, dw, df;
    bit           prev_rst, prev_gnt;
    logic         exp_vld;
    cdb_pkt_t     p;
    logic [1:0]   wi;

    da = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    db = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    dl = {32'h0, 32'hDEADBEEF, 64'h0};
    dw = {32'h99990003, 32'h0, 32'h77770001, 32'h0};
    df = {64'h0, 32'hBBBB0001, 32'hAAAA0000};

    add(1, 0, 4'hF, 16'h4321, da, 4'h0);            // reset beats requests
    add(0, 0, 4'h0, 16'h0000, '0, 4'h0);            // idle
    repeat (3) add(0, 0, 4'h4, 16'h0500, dl, 4'h4); // lone LSU, back-to-back
    add(1, 0, 4'h0, 16'h0000, '0, 4'h0);            // ptr back to 0
    add(0, 0, 4'hF, 16'h4321, da, 4'h1);
    add(0, 0, 4'hF, 16'h4321, da, 4'h2);
    add(0, 0, 4'hF, 16'h4321, da, 4'h4);
    add(0, 0, 4'hF, 16'h4321, da, 4'h8);
    add(0, 0, 4'hF, 16'h4321, da, 4'h1);            // ptr now 1
    add(0, 0, 4'h4, 16'h0600, {32'h0, 32'h66666666, 64'h0}, 4'h4); // ptr 3
    add(0, 0, 4'hA, 16'h9070, dw, 4'h8);            // wrap: unit 3 first
    add(0, 0, 4'h2, 16'h9070, dw, 4'h2);            // then unit 1, ptr 2
    add(0, 1, 4'h3, 16'h00BA, df, 4'h0);            // flush
    add(0, 0, 4'h3, 16'h00BA, df, 4'h1);            // ptr still 2 -> unit 0
    add(0, 0, 4'h2, 16'h00BA, df, 4'h2);
    add(0, 0, 4'hF, 16'hA987, db, 4'h4);            // ptr 2 -> unit 2
    add(1, 0, 4'hF, 16'hA987, db, 4'h0);            // reset mid-stream
    add(0, 0, 4'hF, 16'hA987, db, 4'h1);
    add(0, 0, 4'hF, 16'hA987, db, 4'h2);
    add(0, 0, 4'h0, 16'h0000, '0, 4'h0);
    add(0, 0, 4'h0, 16'h0000, '0, 4'h0);            // outputs hold while idle

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.src_req   = '0;
    bus.src_tag   = '0;
    bus.src_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    prev_rst = 1'b1;
    prev_gnt = 1'b0;
    held     = '0;

    foreach (vt[k]) begin
      rst           = vt[k].rst;
      bus.flush     = vt[k].flush;
      bus.src_req   = vt[k].req;
      bus.src_tag   = vt[k].tags;
      bus.src_wdata = vt[k].datas;
      @(negedge clk);

      if (prev_rst) begin
        held    = '0;
        exp_vld = 1'b0;
      end else if (prev_gnt) begin
        if (sb.size() == 0) begin
          chk("scoreboard_underflow", 1'b1, 1'b0);
          exp_vld = 1'b1;
        end else begin
          held    = sb.pop_front();
          exp_vld = 1'b1;
        end
      end else begin
        exp_vld = 1'b0;
      end

      chk($sformatf("cdb_vld[%0d]", k), bus.cdb_vld, exp_vld);
      chk($sformatf("cdb_tag[%0d]", k), bus.cdb_tag, held.tag);
      chk($sformatf("cdb_data[%0d]", k), bus.cdb_data, held.data);
      chk($sformatf("cdb_src[%0d]", k), bus.cdb_src, held.src);
      chk($sformatf("src_rdy[%0d]", k), bus.src_rdy, vt[k].exp_rdy);

      prev_gnt = !vt[k].rst && (vt[k].exp_rdy != 4'h0);
      prev_rst = vt[k].rst;
      if (prev_gnt) begin
        wi     = oh2idx(vt[k].exp_rdy);
        p.vld  = 1'b1;
        p.tag  = vt[k].tags[wi*4 +: 4];
        p.data = vt[k].datas[wi*32 +: 32];
        p.src  = wi;
        sb.push_back(p);
      end
      @(posedge clk);
      #1;
    end

    // Each unit holding req must win within 4 cycles despite random competitors.
    rst       = 1'b0;
    bus.flush = 1'b0;
    for (int u = 0; u < 4; u++) begin
      int waited;
      bit granted;
      waited  = 0;
      granted = 1'b0;
      while (!granted && waited < 8) begin
        bus.src_req = 4'($urandom_range(0, 15)) | (4'h1 << u);
        @(negedge clk);
        waited++;
        if (bus.src_rdy[u]) granted = 1'b1;
        @(posedge clk);
        #1;
      end
      chk($sformatf("fair_unit%0d_wait%0d", u, waited), (granted && waited <= 4), 1'b1);
    end
    bus.src_req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
